// File: rtl/alu_multicycle_n.sv
// Multi-cycle ALU: ADD/SUB/logic/MOV complete in one cycle, MUL is an
// N-iteration shift-add. Ports: clk, rst_n, start, A_num, B_num,
// ALUControl[2:0] in; result[N-1:0], ALUFlags{V,C,N,Z}, busy, done out.
module alu_multicycle_n #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A_num,
  input  logic [N-1:0] B_num,
  input  logic [2:0]   ALUControl,
  output logic [N-1:0] result,
  output logic [3:0]   ALUFlags,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b100;
  localparam logic [2:0] OP_EOR = 3'b101;
  localparam logic [2:0] OP_BIC = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  acc;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;

  logic [N-1:0]  bx;
  logic          is_sub;
  logic [N:0]    sum;
  logic [N-1:0]  alu_r;
  logic          alu_c;
  logic          alu_v;
  logic [N-1:0]  prod_next;

  // Shared adder: SUB is A + ~B + 1.
  always_comb begin
    is_sub = (ALUControl == OP_SUB);
    bx     = is_sub ? ~B_num : B_num;
    sum    = {1'b0, A_num} + {1'b0, bx}
           + {{N{1'b0}}, is_sub};
    alu_r  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    unique case (ALUControl)
      OP_ADD, OP_SUB: begin
        alu_r = sum[N-1:0];
        alu_c = sum[N];
        alu_v = (A_num[N-1] == bx[N-1])
             && (sum[N-1] != A_num[N-1]);
      end
      OP_AND: alu_r = A_num & B_num;
      OP_ORR: alu_r = A_num | B_num;
      OP_MOV: alu_r = B_num;
      OP_EOR: alu_r = A_num ^ B_num;
      OP_BIC: alu_r = A_num & ~B_num;
      OP_MUL: alu_r = '0;
      default: alu_r = '0;
    endcase
  end

  // Partial product after the current iteration.
  always_comb begin
    prod_next = acc + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      result   <= '0;
      ALUFlags <= 4'b0000;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (ALUControl == OP_MUL) begin
              mcand  <= A_num;
              mplier <= B_num;
              acc    <= '0;
              cnt    <= CW'(N);
              busy   <= 1'b1;
              state  <= S_MUL;
            end else begin
              result   <= alu_r;
              ALUFlags <= {alu_v, alu_c,
                           alu_r[N-1],
                           ~|alu_r};
              done     <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc    <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result   <= prod_next;
            ALUFlags <= {2'b00,
                         prod_next[N-1],
                         ~|prod_next};
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle_n.sv
// Randomized self-checking bench for alu_multicycle_n (N=32)
// against an arithmetic reference model.
module tb_alu_multicycle_n;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [2:0]   op = 3'd0;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  alu_multicycle_n #(.N(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .A_num(a),
    .B_num(b),
    .ALUControl(op),
    .result(result),
    .ALUFlags(flags),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic void model(
    input  logic [2:0]   o,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] r,
    output logic [3:0]   f);
    longint sx, sy, s;
    logic [63:0] p;
    logic c, v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'd0: begin
        r = x + y;
        p = {32'b0, x} + {32'b0, y};
        c = p > 64'hFFFF_FFFF;
        s = sx + sy;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        r = x - y;
        c = x >= y;
        s = sx - sy;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = y;
      3'd5: r = x ^ y;
      3'd6: r = x & ~y;
      default: begin
        p = {32'b0, x} * {32'b0, y};
        r = p[31:0];
      end
    endcase
    f = {v, c, r[N-1], r == 0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; ign=1 injects an ADD start at MUL cycle 5.
  task automatic do_op(input logic [2:0] o,
                       input logic [N-1:0] x,
                       input logic [N-1:0] y,
                       input bit ign);
    logic [N-1:0] er;
    logic [3:0]   ef;
    int cyc;
    bit busy_bad;
    model(o, x, y, er, ef);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (o != 3'd7) begin
      check("alu_done", done, 1);
      check("alu_busy", busy, 0);
    end else begin
      cyc = 0;
      busy_bad = 0;
      while (!done && cyc < N + 8) begin
        if (!busy) busy_bad = 1;
        if (ign && cyc == 5) begin
          op = 3'd0;
          a = 32'h1111_1111;
          b = 32'h2222_2222;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        tick();
        cyc++;
      end
      start = 1'b0;
      check("mul_latency", cyc, N);
      check("mul_busy_hi", busy_bad, 0);
      check("mul_busy_lo", busy, 0);
    end
    check("result", result, er);
    check("flags", flags, ef);
    tick();
    check("done_pulse", done, 0);
    check("hold_result", result, er);
  endtask

  initial begin
    logic [N-1:0] er;
    logic [3:0]   ef;
    logic [2:0]   seq_op [5];
    logic [N-1:0] seq_r  [5];
    bit done_seen;
    seq_op = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd4};
    seq_r  = '{32'hF000_F000, 32'hFFF0_FFF0,
               32'h0FF0_0FF0, 32'h00F0_00F0,
               32'hFF00_FF00};

    #12;
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    do_op(3'd0, 32'h7FFF_FFFF, 32'h1, 0);
    check("add_ovf_flags", flags, 4'b1010);
    do_op(3'd1, 32'd5, 32'd5, 0);
    check("sub_eq_flags", flags, 4'b0101);
    do_op(3'd1, 32'd0, 32'd1, 0);
    check("sub_brw_res", result, 32'hFFFF_FFFF);
    check("sub_brw_flags", flags, 4'b0010);

    // Back-to-back ops with start held high.
    a = 32'hF0F0_F0F0;
    b = 32'hFF00_FF00;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op = seq_op[i];
      tick();
      check("b2b_result", result, seq_r[i]);
      check("b2b_done", done, 1);
    end
    start = 1'b0;
    tick();
    check("b2b_done_end", done, 0);

    do_op(3'd7, 32'h0000_FFFF, 32'h0001_0001, 1);
    check("mul_res", result, 32'hFFFF_FFFF);
    check("mul_flags", flags, 4'b0010);
    do_op(3'd7, 32'h8000_0000, 32'd2, 0);
    check("mul_zero_flags", flags, 4'b0001);

    // Inputs changing without start have no effect.
    a = 32'h1234_5678;
    b = 32'h9;
    op = 3'd0;
    repeat (3) tick();
    check("idle_hold_res", result, 0);
    check("idle_hold_done", done, 0);

    // Reset in the middle of a MUL.
    op = 3'd7;
    a = 32'd1234;
    b = 32'd5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("mid_mul_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_result", result, 0);
    check("arst_flags", flags, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    repeat (N + 4) begin
      tick();
      if (done) done_seen = 1;
    end
    check("abort_no_done", done_seen, 0);
    do_op(3'd0, 32'd2, 32'd3, 0);
    check("post_rst_res", result, 5);
    check("post_rst_flags", flags, 0);

    // Random operations against the model.
    for (int i = 0; i < 60; i++) begin
      logic [2:0] ro;
      logic [N-1:0] ra, rb;
      ro = 3'($urandom_range(7));
      ra = $urandom;
      rb = $urandom;
      if (i % 7 == 0) rb = ra;
      if (i % 11 == 0) ra = 32'h8000_0000;
      do_op(ro, ra, rb, (i % 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_multicycle_n.md
ALU_MULTICYCLE_N -- requirements
Module: alu_multicycle_n

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning operand/result width in bits (N >= 4).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  request; samples operands and opcode when accepted.
REQ-005 The block SHALL have port A_num  input  N  first operand.
REQ-006 The block SHALL have port B_num  input  N  second operand.
REQ-007 The block SHALL have port ALUControl  input  3  operation selector.
REQ-008 The block SHALL have port result  output  N  registered result of the last completed operation.
REQ-009 The block SHALL have port ALUFlags  output  4  registered flags {V,C,N,Z}, bit 3 = V, bit 0 = Z.
REQ-010 The block SHALL have port busy  output  1  high while a multi-cycle operation is in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse marking result/ALUFlags update.

Function
REQ-012 Opcodes SHALL be: 000 ADD, 001 SUB (A-B), 010 AND, 011 ORR, 100 MOV (B), 101 EOR, 110 BIC (A & ~B), 111 MUL; no code is reserved.
REQ-013 States SHALL be IDLE and MUL only; reset state is IDLE.
REQ-014 start SHALL be accepted only in IDLE; start while busy=1 SHALL be ignored and have no effect.
REQ-015 Non-MUL ops: on the accepting edge, result and ALUFlags SHALL update and done SHALL be 1 for the following cycle (latency 1); state stays IDLE.
REQ-016 start held high in IDLE with non-MUL ops SHALL yield one completed operation per cycle, done staying high.
REQ-017 MUL: accepting edge SHALL latch operands, clear accumulator, load iteration counter, enter MUL, set busy=1.
REQ-018 MUL SHALL be shift-add: each MUL-state edge adds the shifted multiplicand when the current multiplier bit is 1; exactly N iterations.
REQ-019 On the N-th iteration edge result SHALL take the low N bits of the product, done SHALL pulse for one cycle, busy SHALL drop, state SHALL return to IDLE; done is first seen N cycles after the accepting edge.
REQ-020 MUL result SHALL be the low N bits of the product (identical for signed and unsigned operands).
REQ-021 ADD/SUB SHALL use one N-bit adder with B inverted and carry-in 1 for SUB; C = adder carry-out (SUB: C=1 means no borrow); V = 1 when both adder inputs share a sign differing from the sum's sign.
REQ-022 Logic ops, MOV and MUL SHALL set N = result[N-1], Z = (result==0), C = 0, V = 0.
REQ-023 ADD/SUB SHALL set N and Z from the result as in REQ-022.
REQ-024 result and ALUFlags SHALL hold their values between completions; operand/opcode changes while not accepted SHALL have no effect.
REQ-025 done SHALL never be high in a cycle with busy=1.

Reset
REQ-026 rst_n=0 SHALL immediately force result=0, ALUFlags=0000, busy=0, done=0, state IDLE, counter and accumulator 0, regardless of clk.
REQ-027 Reset asserted during MUL SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be handled normally.

Verification (N=32)
REQ-028 ADD A=0x7FFFFFFF, B=0x00000001 -> one cycle later result=0x80000000, ALUFlags=1010, done=1 for one cycle.
REQ-029 SUB A=5, B=5 -> result=0x00000000, ALUFlags=0101; SUB A=0, B=1 -> result=0xFFFFFFFF, ALUFlags=0010.
REQ-030 A=0xF0F0F0F0, B=0xFF00FF00 issued back-to-back AND/ORR/EOR/BIC/MOV -> 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0x00F000F0, 0xFF00FF00 on consecutive cycles, done high throughout.
REQ-031 MUL A=0x0000FFFF, B=0x00010001 -> busy high 32 cycles, result=0xFFFFFFFF, ALUFlags=0010, done pulse exactly 32 cycles after acceptance; an ADD start issued at cycle 5 is ignored.
REQ-032 MUL A=0x80000000, B=2 -> result=0x00000000, ALUFlags=0001.
REQ-033 rst_n pulsed low at cycle 10 of a MUL -> outputs 0 asynchronously, no done; subsequent ADD 2+3 -> result=5, ALUFlags=0000.
